// File: rtl/alu_div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package alu_div_pkg;

   localparam int unsigned DIV_WIDTH_DEFAULT = 8;

   // Quotient reported on divide-by-zero or overflow (all ones).
   localparam logic [DIV_WIDTH_DEFAULT-1:0] DIV_ERR_QUOTIENT = '1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } div_state_e;

endpackage

// File: rtl/alu_divider_if.sv
// Start/done request interface between an ALU sequencer and alu_divider.
interface alu_divider_if #(
   parameter int unsigned WIDTH = alu_div_pkg::DIV_WIDTH_DEFAULT
) ();

   logic                 start;
   logic [2*WIDTH-1:0]   dividend;
   logic [WIDTH-1:0]     divisor;
   logic                 busy;
   logic                 done;
   logic [WIDTH-1:0]     quotient;
   logic [WIDTH-1:0]     remainder;
   logic                 div_by_zero;
   logic                 overflow;

   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, div_by_zero, overflow
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, div_by_zero, overflow
   );

endinterface

// File: rtl/alu_divider_div_step.sv
// div_step: one combinational restoring-division step.
module div_step #(
   parameter int unsigned WIDTH = 8
) (
   input  logic [WIDTH-1:0] rem_i,
   input  logic             bit_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic [WIDTH-1:0] rem_o,
   output logic             q_o
);

   logic [WIDTH:0]   shifted;
   logic [WIDTH-1:0] diff;

   // Shift in the next dividend bit, trial-subtract, restore on borrow.
   // The low WIDTH bits of the difference suffice: whenever the subtraction
   // is kept, the true result is below the divisor.
   always_comb begin
      shifted = {rem_i, bit_i};
      diff    = shifted[WIDTH-1:0] - divisor_i;
      q_o     = (shifted >= {1'b0, divisor_i});
      rem_o   = q_o ? diff : shifted[WIDTH-1:0];
   end

endmodule

// File: rtl/alu_divider.sv
// alu_divider: sequential restoring divider, one quotient bit per clock.
// 2*WIDTH-bit dividend / WIDTH-bit divisor behind a start/done handshake.
// Optional macro ALU_DIV_SIGNED_EN: two's-complement operands, truncating.
module alu_divider
   import alu_div_pkg::*;
#(
   parameter int unsigned WIDTH = DIV_WIDTH_DEFAULT
) (
   input  logic         clk,
   input  logic         rst_n,
   alu_divider_if.slave bus
);

   localparam int unsigned       CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [WIDTH-1:0]  ERR_Q    = {WIDTH{DIV_ERR_QUOTIENT[0]}};
`ifdef ALU_DIV_SIGNED_EN
   localparam logic [WIDTH-1:0]  SMIN_MAG = {1'b1, {(WIDTH-1){1'b0}}};
`endif

   div_state_e         state_q, state_d;
   logic [WIDTH-1:0]   divisor_q, divisor_d;
   logic [WIDTH-1:0]   pr_q, pr_d;
   // Low dividend half; quotient bits shift in at the LSB as dividend bits leave the MSB.
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   quotient_q, quotient_d;
   logic [WIDTH-1:0]   remainder_q, remainder_d;
   logic               dbz_q, dbz_d;
   logic               ovf_q, ovf_d;
`ifdef ALU_DIV_SIGNED_EN
   logic               qneg_q, qneg_d;
   logic               rneg_q, rneg_d;
`endif

   logic               accept;
   logic               pre_dbz;
   logic               pre_ovf;
   logic [2*WIDTH-1:0] dvd_mag;
   logic [WIDTH-1:0]   dsr_mag;
   logic [WIDTH-1:0]   step_rem;
   logic               step_q;
   logic [WIDTH-1:0]   q_raw;

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem_i     (pr_q),
      .bit_i     (lo_q[WIDTH-1]),
      .divisor_i (divisor_q),
      .rem_o     (step_rem),
      .q_o       (step_q)
   );

   // Operand magnitudes and early-exit checks evaluated on the request inputs.
   always_comb begin
      dvd_mag = bus.dividend;
      dsr_mag = bus.divisor;
`ifdef ALU_DIV_SIGNED_EN
      if (bus.dividend[2*WIDTH-1]) dvd_mag = -bus.dividend;
      if (bus.divisor[WIDTH-1])    dsr_mag = -bus.divisor;
`endif
      pre_dbz = (dsr_mag == '0);
      pre_ovf = (dvd_mag[2*WIDTH-1:WIDTH] >= dsr_mag);
      accept  = bus.start && (state_q != RUN);
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         divisor_q   <= '0;
         pr_q        <= '0;
         lo_q        <= '0;
         cnt_q       <= '0;
         quotient_q  <= '0;
         remainder_q <= '0;
         dbz_q       <= 1'b0;
         ovf_q       <= 1'b0;
`ifdef ALU_DIV_SIGNED_EN
         qneg_q      <= 1'b0;
         rneg_q      <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         divisor_q   <= divisor_d;
         pr_q        <= pr_d;
         lo_q        <= lo_d;
         cnt_q       <= cnt_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         dbz_q       <= dbz_d;
         ovf_q       <= ovf_d;
`ifdef ALU_DIV_SIGNED_EN
         qneg_q      <= qneg_d;
         rneg_q      <= rneg_d;
`endif
      end
   end

   // Next-state logic: accept from IDLE/DONE, iterate WIDTH steps in RUN.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE, DONE: begin
            if (accept) state_d = (pre_dbz || pre_ovf) ? DONE : RUN;
            else        state_d = IDLE;
         end
         RUN: begin
            if (cnt_q == '0) state_d = DONE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Datapath: operand capture, restoring steps, result update on entry to DONE.
   always_comb begin
      divisor_d   = divisor_q;
      pr_d        = pr_q;
      lo_d        = lo_q;
      cnt_d       = cnt_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      dbz_d       = dbz_q;
      ovf_d       = ovf_q;
`ifdef ALU_DIV_SIGNED_EN
      qneg_d      = qneg_q;
      rneg_d      = rneg_q;
`endif
      q_raw       = {lo_q[WIDTH-2:0], step_q};

      if (accept) begin
         divisor_d = dsr_mag;
         pr_d      = dvd_mag[2*WIDTH-1:WIDTH];
         lo_d      = dvd_mag[WIDTH-1:0];
         cnt_d     = CNT_LAST;
         dbz_d     = 1'b0;
         ovf_d     = 1'b0;
`ifdef ALU_DIV_SIGNED_EN
         qneg_d    = bus.dividend[2*WIDTH-1] ^ bus.divisor[WIDTH-1];
         rneg_d    = bus.dividend[2*WIDTH-1];
`endif
         if (pre_dbz) begin
            dbz_d       = 1'b1;
            quotient_d  = ERR_Q;
            remainder_d = '0;
         end else if (pre_ovf) begin
            ovf_d       = 1'b1;
            quotient_d  = ERR_Q;
            remainder_d = '0;
         end
      end else if (state_q == RUN) begin
         pr_d  = step_rem;
         lo_d  = q_raw;
         cnt_d = cnt_q - CNT_W'(1);
         if (cnt_q == '0) begin
`ifdef ALU_DIV_SIGNED_EN
            // Negative results may reach -2^(WIDTH-1); positive stop one short.
            if (qneg_q ? (q_raw > SMIN_MAG) : (q_raw >= SMIN_MAG)) begin
               ovf_d       = 1'b1;
               quotient_d  = ERR_Q;
               remainder_d = '0;
            end else begin
               quotient_d  = qneg_q ? -q_raw : q_raw;
               remainder_d = rneg_q ? -step_rem : step_rem;
            end
`else
            quotient_d  = q_raw;
            remainder_d = step_rem;
`endif
         end
      end
   end

   // Outputs decoded from state and held result registers.
   always_comb begin
      bus.busy        = (state_q == RUN);
      bus.done        = (state_q == DONE);
      bus.quotient    = quotient_q;
      bus.remainder   = remainder_q;
      bus.div_by_zero = dbz_q;
      bus.overflow    = ovf_q;
   end

endmodule

// File: tb/tb_alu_divider.sv
// Self-checking bench for alu_divider; a scoreboard monitor checks every done pulse.
module tb_alu_divider;

   localparam int unsigned W = 8;

   typedef struct {
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dbz;
      logic         ovf;
      int           lat;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;
   exp_t sb[$];
   exp_t mon_e;

   alu_divider_if #(.WIDTH(W)) dut_if ();
   alu_divider #(.WIDTH(W)) u_dut (.clk(clk), .rst_n(rst_n), .bus(dut_if));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference model: native division, edge-count latency after accept.
   function automatic exp_t model(input logic [2*W-1:0] dvd, input logic [W-1:0] dsr);
      exp_t e;
`ifdef ALU_DIV_SIGNED_EN
      int sd, sv, md, mv, qi, ri;
      sd = int'($signed(dvd));
      sv = int'($signed(dsr));
      md = (sd < 0) ? -sd : sd;
      mv = (sv < 0) ? -sv : sv;
      e.q = '1; e.r = '0; e.dbz = 1'b0; e.ovf = 1'b0; e.lat = 0;
      if (sv == 0) e.dbz = 1'b1;
      else if ((md >> W) >= mv) e.ovf = 1'b1;
      else begin
         e.lat = W;
         qi = sd / sv;
         ri = sd % sv;
         if (qi > (1 << (W-1)) - 1 || qi < -(1 << (W-1))) e.ovf = 1'b1;
         else begin
            e.q = W'(qi);
            e.r = W'(ri);
         end
      end
`else
      e.q = '1; e.r = '0; e.dbz = 1'b0; e.ovf = 1'b0; e.lat = 0;
      if (dsr == '0) e.dbz = 1'b1;
      else if (dvd[2*W-1:W] >= dsr) e.ovf = 1'b1;
      else begin
         e.lat = W;
         e.q = W'(dvd / {{W{1'b0}}, dsr});
         e.r = W'(dvd % {{W{1'b0}}, dsr});
      end
`endif
      return e;
   endfunction

   // Scoreboard monitor: every done cycle retires the oldest expected result.
   always @(posedge clk) begin
      #1;
      if (rst_n === 1'b1 && dut_if.done === 1'b1) begin
         if (sb.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL sb_unexpected_done: got done=1 required no pending result (t=%0t)", $time);
         end else begin
            mon_e = sb.pop_front();
            n_tests++;
            if (dut_if.quotient !== mon_e.q) begin
               n_fail++;
               $display("FAIL sb_quotient: got %h required %h (t=%0t)", dut_if.quotient, mon_e.q, $time);
            end
            n_tests++;
            if (dut_if.remainder !== mon_e.r) begin
               n_fail++;
               $display("FAIL sb_remainder: got %h required %h (t=%0t)", dut_if.remainder, mon_e.r, $time);
            end
            n_tests++;
            if (dut_if.div_by_zero !== mon_e.dbz) begin
               n_fail++;
               $display("FAIL sb_div_by_zero: got %b required %b (t=%0t)", dut_if.div_by_zero, mon_e.dbz, $time);
            end
            n_tests++;
            if (dut_if.overflow !== mon_e.ovf) begin
               n_fail++;
               $display("FAIL sb_overflow: got %b required %b (t=%0t)", dut_if.overflow, mon_e.ovf, $time);
            end
         end
      end
   end

   // Drive one request; returns the cycle stamp of accept edge E (sampled E+1ns).
   task automatic issue(input logic [2*W-1:0] dvd, input logic [W-1:0] dsr, output int e_cyc);
      @(negedge clk);
      dut_if.start    = 1'b1;
      dut_if.dividend = dvd;
      dut_if.divisor  = dsr;
      sb.push_back(model(dvd, dsr));
      @(posedge clk);
      #1;
      e_cyc = cyc;
      dut_if.start = 1'b0;
   endtask

   // Bounded wait for done; returns its cycle stamp or -1 on timeout.
   task automatic wait_done(output int d_cyc);
      d_cyc = -1;
      for (int k = 0; k < 40; k++) begin
         if (dut_if.done === 1'b1) begin
            d_cyc = cyc;
            break;
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      #1;
      n_tests++; if (dut_if.busy !== 1'b0)        begin n_fail++; $display("FAIL reset_busy: got %b required 0", dut_if.busy); end
      n_tests++; if (dut_if.done !== 1'b0)        begin n_fail++; $display("FAIL reset_done: got %b required 0", dut_if.done); end
      n_tests++; if (dut_if.quotient !== 8'h00)   begin n_fail++; $display("FAIL reset_quotient: got %h required 00", dut_if.quotient); end
      n_tests++; if (dut_if.remainder !== 8'h00)  begin n_fail++; $display("FAIL reset_remainder: got %h required 00", dut_if.remainder); end
      n_tests++; if (dut_if.div_by_zero !== 1'b0) begin n_fail++; $display("FAIL reset_dbz: got %b required 0", dut_if.div_by_zero); end
      n_tests++; if (dut_if.overflow !== 1'b0)    begin n_fail++; $display("FAIL reset_ovf: got %b required 0", dut_if.overflow); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      int e_cyc, d_cyc;
      exp_t e;
      e = model(16'h03E8, 8'd7);
      issue(16'h03E8, 8'd7, e_cyc);
      n_tests++; if (dut_if.busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b required 1", dut_if.busy); end
      wait_done(d_cyc);
      n_tests++; if (d_cyc - e_cyc !== W) begin n_fail++; $display("FAIL basic_latency: got %0d required %0d", d_cyc - e_cyc, W); end
      n_tests++; if (dut_if.busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_done: got %b required 0", dut_if.busy); end
`ifndef ALU_DIV_SIGNED_EN
      n_tests++; if (dut_if.quotient !== 8'd142) begin n_fail++; $display("FAIL basic_q142: got %0d required 142", dut_if.quotient); end
      n_tests++; if (dut_if.remainder !== 8'd6)  begin n_fail++; $display("FAIL basic_r6: got %0d required 6", dut_if.remainder); end
`endif
      repeat (3) @(posedge clk);
      #1;
      n_tests++; if (dut_if.done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse: got %b required 0", dut_if.done); end
      n_tests++; if (dut_if.quotient !== e.q) begin n_fail++; $display("FAIL basic_hold: got %h required %h", dut_if.quotient, e.q); end
   endtask

   task automatic test_errors();
      int e_cyc, d_cyc;
      exp_t e;
      issue(16'h1234, 8'h00, e_cyc);
      wait_done(d_cyc);
      n_tests++; if (d_cyc - e_cyc !== 0) begin n_fail++; $display("FAIL dbz_latency: got %0d required 0", d_cyc - e_cyc); end
      n_tests++; if (dut_if.div_by_zero !== 1'b1) begin n_fail++; $display("FAIL dbz_flag: got %b required 1", dut_if.div_by_zero); end
      n_tests++; if (dut_if.quotient !== 8'hFF) begin n_fail++; $display("FAIL dbz_quotient: got %h required ff", dut_if.quotient); end
      e = model(16'hFFFF, 8'hFF);
      issue(16'hFFFF, 8'hFF, e_cyc);
      wait_done(d_cyc);
      n_tests++; if (d_cyc - e_cyc !== e.lat) begin n_fail++; $display("FAIL ovf_latency: got %0d required %0d", d_cyc - e_cyc, e.lat); end
      n_tests++; if (dut_if.div_by_zero !== 1'b0) begin n_fail++; $display("FAIL ovf_dbz_clear: got %b required 0", dut_if.div_by_zero); end
      e = model(16'hFEFF, 8'hFF);
      issue(16'hFEFF, 8'hFF, e_cyc);
      wait_done(d_cyc);
      n_tests++; if (d_cyc - e_cyc !== e.lat) begin n_fail++; $display("FAIL edge_latency: got %0d required %0d", d_cyc - e_cyc, e.lat); end
   endtask

   task automatic test_roundtrip();
      int e_cyc, d_cyc;
      exp_t e;
      e = model(16'h0A28, 8'd13);
      issue(16'h0A28, 8'd13, e_cyc);
      wait_done(d_cyc);
      n_tests++; if (d_cyc - e_cyc !== e.lat) begin n_fail++; $display("FAIL rt_latency: got %0d required %0d", d_cyc - e_cyc, e.lat); end
`ifndef ALU_DIV_SIGNED_EN
      n_tests++; if (dut_if.quotient !== 8'd200) begin n_fail++; $display("FAIL rt_q200: got %0d required 200", dut_if.quotient); end
`endif
      issue(16'h00FE, 8'hFF, e_cyc);
      wait_done(d_cyc);
`ifndef ALU_DIV_SIGNED_EN
      n_tests++; if (dut_if.quotient !== 8'h00 || dut_if.remainder !== 8'hFE) begin
         n_fail++; $display("FAIL rt_small: got q=%h r=%h required q=00 r=fe", dut_if.quotient, dut_if.remainder);
      end
`endif
   endtask

   task automatic test_ignore_busy();
      int e_cyc, d_cyc;
      issue(16'h0A28, 8'd13, e_cyc);
      repeat (3) @(negedge clk);
      dut_if.start    = 1'b1;
      dut_if.dividend = 16'h1234;
      dut_if.divisor  = 8'd5;
      @(posedge clk);
      #1;
      dut_if.start = 1'b0;
      n_tests++; if (dut_if.busy !== 1'b1) begin n_fail++; $display("FAIL ign_busy: got %b required 1", dut_if.busy); end
      wait_done(d_cyc);
      n_tests++; if (d_cyc - e_cyc !== W) begin n_fail++; $display("FAIL ign_latency: got %0d required %0d", d_cyc - e_cyc, W); end
   endtask

   task automatic test_back_to_back();
      int e_cyc, d_cyc;
      issue(16'h03E8, 8'd7, e_cyc);
      wait_done(d_cyc);
      issue(16'h0A28, 8'd13, e_cyc);
      n_tests++; if (dut_if.busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy: got %b required 1", dut_if.busy); end
      n_tests++; if (dut_if.done !== 1'b0) begin n_fail++; $display("FAIL b2b_done: got %b required 0", dut_if.done); end
      wait_done(d_cyc);
      n_tests++; if (d_cyc - e_cyc !== W) begin n_fail++; $display("FAIL b2b_latency: got %0d required %0d", d_cyc - e_cyc, W); end
      issue(16'h1234, 8'h00, e_cyc);
      wait_done(d_cyc);
      issue(16'h5678, 8'h00, e_cyc);
      wait_done(d_cyc);
      n_tests++; if (d_cyc - e_cyc !== 0) begin n_fail++; $display("FAIL b2b_err_latency: got %0d required 0", d_cyc - e_cyc); end
   endtask

   task automatic test_random();
      logic [W-1:0]   dsr, hi, lo;
      logic [2*W-1:0] dvd;
      int             e_cyc, d_cyc;
      exp_t           e;
      for (int i = 0; i < 16; i++) begin
         dsr = W'($urandom_range(0, (1 << W) - 1));
         lo  = W'($urandom);
         if (i % 4 == 3 || dsr == '0) hi = W'($urandom);
         else hi = W'($urandom_range(0, int'(dsr) - 1));
         dvd = {hi, lo};
         e = model(dvd, dsr);
         issue(dvd, dsr, e_cyc);
         wait_done(d_cyc);
         n_tests++;
         if (d_cyc - e_cyc !== e.lat) begin
            n_fail++; $display("FAIL rand_latency: %h/%h got %0d required %0d", dvd, dsr, d_cyc - e_cyc, e.lat);
         end
      end
   endtask

   task automatic test_reset_abort();
      int e_cyc, d_cyc, seen;
      issue(16'h03E8, 8'd7, e_cyc);
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_tests++; if ({dut_if.busy, dut_if.done, dut_if.div_by_zero, dut_if.overflow} !== 4'b0000) begin
         n_fail++; $display("FAIL abort_ctrl: got %b required 0000", {dut_if.busy, dut_if.done, dut_if.div_by_zero, dut_if.overflow});
      end
      n_tests++; if ({dut_if.quotient, dut_if.remainder} !== 16'h0000) begin
         n_fail++; $display("FAIL abort_result: got %h required 0000", {dut_if.quotient, dut_if.remainder});
      end
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk);
         #1;
         if (dut_if.done === 1'b1) seen++;
      end
      n_tests++; if (seen !== 0) begin n_fail++; $display("FAIL abort_no_done: got %0d pulses required 0", seen); end
      issue(16'h03E8, 8'd7, e_cyc);
      wait_done(d_cyc);
      n_tests++; if (d_cyc - e_cyc !== W) begin n_fail++; $display("FAIL abort_restart: got %0d required %0d", d_cyc - e_cyc, W); end
   endtask

`ifdef ALU_DIV_SIGNED_EN
   task automatic test_signed();
      int e_cyc, d_cyc;
      issue(16'hFF9C, 8'd7, e_cyc);
      wait_done(d_cyc);
      n_tests++; if (d_cyc - e_cyc !== W) begin n_fail++; $display("FAIL s_latency: got %0d required %0d", d_cyc - e_cyc, W); end
      n_tests++; if (dut_if.quotient !== 8'hF2 || dut_if.remainder !== 8'hFE) begin
         n_fail++; $display("FAIL s_neg100_7: got q=%h r=%h required q=f2 r=fe", dut_if.quotient, dut_if.remainder);
      end
      issue(16'h8000, 8'd1, e_cyc);
      wait_done(d_cyc);
      n_tests++; if (dut_if.overflow !== 1'b1 || d_cyc - e_cyc !== 0) begin
         n_fail++; $display("FAIL s_min_ovf: got ovf=%b lat=%0d required ovf=1 lat=0", dut_if.overflow, d_cyc - e_cyc);
      end
      issue(16'h7F00, 8'h80, e_cyc);
      wait_done(d_cyc);
      n_tests++; if (dut_if.overflow !== 1'b1 || d_cyc - e_cyc !== W) begin
         n_fail++; $display("FAIL s_late_ovf: got ovf=%b lat=%0d required ovf=1 lat=%0d", dut_if.overflow, d_cyc - e_cyc, W);
      end
   endtask
`endif

   initial begin
      dut_if.start    = 1'b0;
      dut_if.dividend = '0;
      dut_if.divisor  = '0;
      test_reset();
      test_basic();
      test_errors();
      test_roundtrip();
      test_ignore_busy();
      test_back_to_back();
      test_random();
      test_reset_abort();
`ifdef ALU_DIV_SIGNED_EN
      test_signed();
`endif
      repeat (3) @(posedge clk);
      #2;
      n_tests++; if (sb.size() !== 0) begin n_fail++; $display("FAIL sb_drained: got %0d pending required 0", sb.size()); end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
